// File: rtl/sample_pacer.sv
// sample_pacer: reads I/Q byte pairs from the sample FIFO and releases one
// pair per programmable sample period as held 8-bit multipliers. It owns
// FIFO read sequencing and pair alignment, and it counts underrun periods.
module sample_pacer #(
    parameter logic [15:0] DEFAULT_DIV      = 16'd99,
    parameter logic [15:0] MIN_DIV          = 16'd4,
    parameter bit          HOLD_ON_UNDERRUN = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] cfg_data,
    input  logic       cfg_wr_lo,
    input  logic       cfg_wr_hi,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_data,
    output logic       fifo_rd,
    output logic [7:0] sample_i,
    output logic [7:0] sample_q,
    output logic       sample_stb,
    input  logic       underrun_clr,
    output logic [7:0] underrun_cnt
);

    typedef enum logic [1:0] {
        F_IDLE   = 2'd0,
        F_CAP_I  = 2'd1,
        F_WAIT_Q = 2'd2,
        F_CAP_Q  = 2'd3
    } fetch_state_e;

    // Dividers below the minimum cannot sustain a 3-cycle pair fetch.
    function automatic logic [15:0] clamp_div(input logic [15:0] d);
        if (d < MIN_DIV) begin
            clamp_div = MIN_DIV;
        end else begin
            clamp_div = d;
        end
    endfunction

    // Saturating increment for the 8-bit underrun counter.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        if (v == 8'hFF) begin
            sat_inc8 = 8'hFF;
        end else begin
            sat_inc8 = v + 8'd1;
        end
    endfunction

    fetch_state_e state_q, state_d;
    logic [15:0]  cnt_q, cnt_d;
    logic [15:0]  shadow_q, shadow_d;
    logic [15:0]  div_active_q, div_active_d;
    logic [7:0]   i_stage_q, i_stage_d;
    logic [7:0]   next_i_q, next_i_d;
    logic [7:0]   next_q_q, next_q_d;
    logic         next_valid_q, next_valid_d;
    logic [7:0]   sample_i_q, sample_i_d;
    logic [7:0]   sample_q_q, sample_q_d;
    logic         stb_q, stb_d;
    logic [7:0]   urun_q, urun_d;
    logic         tick_s;
    logic         rd_s;
    logic         cap_pair_s;

    // A tick ends the current period; the counter only runs while enabled.
    assign tick_s = en && (cnt_q == div_active_q);

    // Reads are suppressed during reset so a held reset never drains the FIFO.
    assign fifo_rd = rd_s && !rst;

    assign sample_i     = sample_i_q;
    assign sample_q     = sample_q_q;
    assign sample_stb   = stb_q;
    assign underrun_cnt = urun_q;

    // Period counter, divider shadow bytes and the active divider reload.
    always_comb begin
        cnt_d        = cnt_q;
        shadow_d     = shadow_q;
        div_active_d = div_active_q;
        if (!en) begin
            cnt_d = 16'd0;
        end else if (tick_s) begin
            cnt_d = 16'd0;
        end else begin
            cnt_d = cnt_q + 16'd1;
        end
        if (cfg_wr_lo) begin
            shadow_d[7:0] = cfg_data;
        end else begin
            shadow_d[7:0] = shadow_q[7:0];
        end
        if (cfg_wr_hi) begin
            shadow_d[15:8] = cfg_data;
        end else begin
            shadow_d[15:8] = shadow_q[15:8];
        end
        // Reloading only at period boundaries keeps the running period intact.
        if (tick_s || !en) begin
            div_active_d = clamp_div(shadow_q);
        end else begin
            div_active_d = div_active_q;
        end
    end

    // Fetch FSM: reads I then Q; once started a pair always completes.
    always_comb begin
        state_d    = state_q;
        rd_s       = 1'b0;
        i_stage_d  = i_stage_q;
        cap_pair_s = 1'b0;
        case (state_q)
            F_IDLE: begin
                if (en && !next_valid_q && !fifo_empty) begin
                    rd_s    = 1'b1;
                    state_d = F_CAP_I;
                end else begin
                    state_d = F_IDLE;
                end
            end
            F_CAP_I: begin
                i_stage_d = fifo_data;
                if (!fifo_empty) begin
                    rd_s    = 1'b1;
                    state_d = F_CAP_Q;
                end else begin
                    state_d = F_WAIT_Q;
                end
            end
            F_WAIT_Q: begin
                if (!fifo_empty) begin
                    rd_s    = 1'b1;
                    state_d = F_CAP_Q;
                end else begin
                    state_d = F_WAIT_Q;
                end
            end
            F_CAP_Q: begin
                cap_pair_s = 1'b1;
                state_d    = F_IDLE;
            end
            default: begin
                state_d = F_IDLE;
            end
        endcase
    end

    // Staged pair, presented sample and underrun accounting on each tick.
    always_comb begin
        next_i_d     = next_i_q;
        next_q_d     = next_q_q;
        next_valid_d = next_valid_q;
        sample_i_d   = sample_i_q;
        sample_q_d   = sample_q_q;
        stb_d        = tick_s;
        urun_d       = urun_q;
        // A capture and a consuming tick never coincide: fetching only starts
        // while no pair is staged, so the staged flag is low during F_CAP_Q.
        if (cap_pair_s) begin
            next_i_d     = i_stage_q;
            next_q_d     = fifo_data;
            next_valid_d = 1'b1;
        end else if (tick_s && next_valid_q) begin
            next_valid_d = 1'b0;
        end else begin
            next_valid_d = next_valid_q;
        end
        if (tick_s && next_valid_q) begin
            sample_i_d = next_i_q;
            sample_q_d = next_q_q;
            urun_d     = underrun_clr ? 8'd0 : urun_q;
        end else if (tick_s) begin
            if (HOLD_ON_UNDERRUN == 1'b1) begin
                sample_i_d = sample_i_q;
                sample_q_d = sample_q_q;
            end else begin
                sample_i_d = 8'h00;
                sample_q_d = 8'h00;
            end
            // Clear first, then count this underrun.
            urun_d = sat_inc8(underrun_clr ? 8'd0 : urun_q);
        end else begin
            urun_d = underrun_clr ? 8'd0 : urun_q;
        end
    end

    // State registers with synchronous reset; a reset discards any partial pair.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= F_IDLE;
            cnt_q        <= 16'd0;
            shadow_q     <= DEFAULT_DIV;
            div_active_q <= DEFAULT_DIV;
            i_stage_q    <= 8'h00;
            next_i_q     <= 8'h00;
            next_q_q     <= 8'h00;
            next_valid_q <= 1'b0;
            sample_i_q   <= 8'h00;
            sample_q_q   <= 8'h00;
            stb_q        <= 1'b0;
            urun_q       <= 8'h00;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            shadow_q     <= shadow_d;
            div_active_q <= div_active_d;
            i_stage_q    <= i_stage_d;
            next_i_q     <= next_i_d;
            next_q_q     <= next_q_d;
            next_valid_q <= next_valid_d;
            sample_i_q   <= sample_i_d;
            sample_q_q   <= sample_q_d;
            stb_q        <= stb_d;
            urun_q       <= urun_d;
        end
    end

endmodule

// File: tb/tb_sample_pacer.sv
// Directed bench for sample_pacer: dut0 zeroes on underrun, dut1 holds.
module tb_sample_pacer;

    logic       clk;
    logic       rst;
    logic       en0, en1;
    logic [7:0] cfg_data;
    logic       cfg_wr_lo, cfg_wr_hi;
    logic       clr;
    logic       fifo_empty0, fifo_empty1;
    logic [7:0] fifo_data0, fifo_data1;
    logic       fifo_rd0, fifo_rd1;
    logic [7:0] si0, sq0, ucnt0, si1, sq1, ucnt1;
    logic       stb0, stb1;

    int n_checks;
    int n_fail;

    // Simple FIFO models with legacy (registered) read data.
    logic [7:0] mem0 [0:63];
    logic [7:0] mem1 [0:63];
    int wr0, rd0, wr1, rd1;
    assign fifo_empty0 = (wr0 == rd0);
    assign fifo_empty1 = (wr1 == rd1);

    always @(posedge clk) begin
        if (fifo_rd0) begin
            fifo_data0 <= mem0[rd0[5:0]];
            rd0 <= rd0 + 1;
        end
        if (fifo_rd1) begin
            fifo_data1 <= mem1[rd1[5:0]];
            rd1 <= rd1 + 1;
        end
    end

    sample_pacer #(.DEFAULT_DIV(16'd99), .MIN_DIV(16'd4), .HOLD_ON_UNDERRUN(1'b0)) dut0 (
        .clk(clk), .rst(rst), .en(en0), .cfg_data(cfg_data),
        .cfg_wr_lo(cfg_wr_lo), .cfg_wr_hi(cfg_wr_hi),
        .fifo_empty(fifo_empty0), .fifo_data(fifo_data0), .fifo_rd(fifo_rd0),
        .sample_i(si0), .sample_q(sq0), .sample_stb(stb0),
        .underrun_clr(clr), .underrun_cnt(ucnt0)
    );

    sample_pacer #(.DEFAULT_DIV(16'd99), .MIN_DIV(16'd4), .HOLD_ON_UNDERRUN(1'b1)) dut1 (
        .clk(clk), .rst(rst), .en(en1), .cfg_data(cfg_data),
        .cfg_wr_lo(cfg_wr_lo), .cfg_wr_hi(cfg_wr_hi),
        .fifo_empty(fifo_empty1), .fifo_data(fifo_data1), .fifo_rd(fifo_rd1),
        .sample_i(si1), .sample_q(sq1), .sample_stb(stb1),
        .underrun_clr(clr), .underrun_cnt(ucnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push0(input logic [7:0] d);
        mem0[wr0[5:0]] = d;
        wr0 = wr0 + 1;
    endtask

    task automatic push1(input logic [7:0] d);
        mem1[wr1[5:0]] = d;
        wr1 = wr1 + 1;
    endtask

    // Writes lo then hi byte; returns two negedges after the call.
    task automatic wr_div(input logic [15:0] d);
        cfg_data  = d[7:0];
        cfg_wr_lo = 1'b1;
        @(negedge clk);
        cfg_wr_lo = 1'b0;
        cfg_data  = d[15:8];
        cfg_wr_hi = 1'b1;
        @(negedge clk);
        cfg_wr_hi = 1'b0;
        cfg_data  = 8'h00;
    endtask

    // Counts negedges until the selected strobe is seen, bounded.
    task automatic wait_stb(input int sel, input int max_cyc, output int cyc);
        logic s;
        cyc = 0;
        s   = 1'b0;
        while (!s && cyc < max_cyc) begin
            @(negedge clk);
            cyc++;
            s = (sel == 0) ? stb0 : stb1;
        end
        if (!s) check("stb_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int base0;
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        en0       = 1'b1;
        en1       = 1'b0;
        cfg_data  = 8'h00;
        cfg_wr_lo = 1'b0;
        cfg_wr_hi = 1'b0;
        clr       = 1'b0;

        // 1. Reset with a non-empty FIFO and en high: no reads, outputs zero.
        push0(8'hEE);
        repeat (3) @(negedge clk);
        check("rst_fifo_rd", {31'd0, fifo_rd0}, 32'd0);
        check("rst_sample_i", {24'd0, si0}, 32'd0);
        check("rst_sample_q", {24'd0, sq0}, 32'd0);
        check("rst_stb", {31'd0, stb0}, 32'd0);
        check("rst_ucnt", {24'd0, ucnt0}, 32'd0);
        rst = 1'b0;
        en0 = 1'b0;
        repeat (5) @(negedge clk);
        check("no_read_en_low", rd0, 32'd0);
        wr0 = rd0;

        // 2. Two pairs at div=9, then underruns.
        wr_div(16'd9);
        repeat (2) @(negedge clk);
        base0 = rd0;
        push0(8'h11); push0(8'h22); push0(8'h33); push0(8'h44);
        en0 = 1'b1;
        wait_stb(0, 50, c);
        check("first_period", c, 32'd10);
        check("pair1_i", {24'd0, si0}, 32'h11);
        check("pair1_q", {24'd0, sq0}, 32'h22);
        check("pair1_ucnt", {24'd0, ucnt0}, 32'd0);
        wait_stb(0, 50, c);
        check("period_10", c, 32'd10);
        check("pair2_i", {24'd0, si0}, 32'h33);
        check("pair2_q", {24'd0, sq0}, 32'h44);
        wait_stb(0, 50, c);
        check("urun1_i", {24'd0, si0}, 32'h00);
        check("urun1_q", {24'd0, sq0}, 32'h00);
        check("urun1_cnt", {24'd0, ucnt0}, 32'd1);
        wait_stb(0, 50, c);
        check("urun2_cnt", {24'd0, ucnt0}, 32'd2);
        check("read_count", rd0 - base0, 32'd4);

        // 3. Clamp to MIN_DIV, then mid-stream change to 0x0100.
        wr_div(16'h0002);
        wait_stb(0, 50, c);
        check("period_unchanged", c, 32'd8);
        wait_stb(0, 50, c);
        check("period_clamped", c, 32'd5);
        wait_stb(0, 50, c);
        check("period_clamped2", c, 32'd5);
        wr_div(16'h0100);
        wait_stb(0, 50, c);
        check("period_before_load", c, 32'd3);
        wait_stb(0, 300, c);
        check("period_257", c, 32'd257);
        check("urun_cnt_7", {24'd0, ucnt0}, 32'd7);
        en0 = 1'b0;

        // 4. Split pair: I present, Q late.
        wr_div(16'd9);
        repeat (2) @(negedge clk);
        base0 = rd0;
        push0(8'h7F);
        en0 = 1'b1;
        wait_stb(0, 50, c);
        check("split_period", c, 32'd10);
        check("split_urun_i", {24'd0, si0}, 32'h00);
        check("split_urun_q", {24'd0, sq0}, 32'h00);
        check("split_urun_cnt", {24'd0, ucnt0}, 32'd8);
        check("split_one_read", rd0 - base0, 32'd1);
        push0(8'h80);
        wait_stb(0, 50, c);
        check("split_pair_i", {24'd0, si0}, 32'h7F);
        check("split_pair_q", {24'd0, sq0}, 32'h80);
        check("split_cnt_same", {24'd0, ucnt0}, 32'd8);
        en0 = 1'b0;

        // 5. Hold-on-underrun instance, saturation and clear.
        wr_div(16'd4);
        repeat (2) @(negedge clk);
        push1(8'h10); push1(8'hF0);
        en1 = 1'b1;
        wait_stb(1, 50, c);
        check("hold_period", c, 32'd5);
        check("hold_pair_i", {24'd0, si1}, 32'h10);
        check("hold_pair_q", {24'd0, sq1}, 32'hF0);
        wait_stb(1, 20, c);
        check("hold_urun_i", {24'd0, si1}, 32'h10);
        check("hold_urun_q", {24'd0, sq1}, 32'hF0);
        check("hold_urun_cnt", {24'd0, ucnt1}, 32'd1);
        for (int i = 2; i <= 300; i++) begin
            wait_stb(1, 20, c);
            if (i == 254) check("cnt_254", {24'd0, ucnt1}, 32'd254);
        end
        check("cnt_saturated", {24'd0, ucnt1}, 32'd255);
        check("sat_hold_i", {24'd0, si1}, 32'h10);
        wait_stb(1, 20, c);
        repeat (4) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("clr_tick_stb", {31'd0, stb1}, 32'd1);
        check("clr_on_tick", {24'd0, ucnt1}, 32'd1);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("clr_no_tick", {24'd0, ucnt1}, 32'd0);
        en1 = 1'b0;

        // 6. Reset during F_CAP_I discards the partial pair.
        base0 = rd0;
        push0(8'h55); push0(8'h66);
        en0 = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_gates_rd", {31'd0, fifo_rd0}, 32'd0);
        repeat (2) @(negedge clk);
        check("rst_mid_reads", rd0 - base0, 32'd1);
        check("rst_mid_i", {24'd0, si0}, 32'h00);
        check("rst_mid_ucnt", {24'd0, ucnt0}, 32'd0);
        wr0 = rd0;
        push0(8'hA1); push0(8'hB2);
        rst = 1'b0;
        wait_stb(0, 150, c);
        check("default_period", c, 32'd100);
        check("restart_i", {24'd0, si0}, 32'hA1);
        check("restart_q", {24'd0, sq0}, 32'hB2);
        check("restart_ucnt", {24'd0, ucnt0}, 32'd0);
        en0 = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
